uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
// Parametrised UART transmitter; successor to the fixed 8N1 TX path.
// Configurable baud divisor, data width, parity and stop bits.
// Input-side FIFO with valid/ready handshake, so the host can queue words and get gap-free frames.
// Sits between the command/data logic and the serial TX pin.
// PARAMETERS
// CLKS_PER_BIT  434  clk cycles per serial bit (50 MHz / 115200); legal >= 2
// DATA_BITS     8    data bits per frame; legal 5..9
// PARITY        0    0 = none, 1 = odd, 2 = even
// STOP_BITS     1    1 or 2
// FIFO_DEPTH    4    queue entries; power of two, >= 2
// PORTS
// clk         in   1                        system clock, rising edge
// rst         in   1                        synchronous reset, active high
// tx_data     in   DATA_BITS                word to send
// tx_valid    in   1                        tx_data valid this cycle
// tx_ready    out  1                        FIFO can accept a word
// data_out    out  1                        serial line, idle high
// tx_busy     out  1                        frame in progress or FIFO non-empty
// fifo_level  out  $clog2(FIFO_DEPTH)+1     words queued, not yet started
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): data_out=1, tx_busy=0, fifo_level=0, FSM=IDLE, all counters 0.
//   tx_ready=0 while rst=1; tx_ready=1 the cycle after rst drops.
// - Reset mid-frame aborts the frame: line returns high on the next edge; queued words are discarded.
// - Handshake: word accepted on the edge where tx_valid & tx_ready.
//   tx_ready = !full (combinational from registered state). No dependence on tx_valid.
// - When full, a push is refused even if a pop happens in the same cycle.
// - Push and pop in the same cycle with FIFO not full: fifo_level unchanged.
// - Words leave the FIFO in arrival order.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
//   - IDLE: data_out=1. If FIFO non-empty, pop into shift register -> START.
//   - START: data_out=0 for CLKS_PER_BIT cycles -> DATA.
//   - DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles -> PARITY if PARITY!=0, else STOP.
//   - PARITY: odd -> bit = ~^data; even -> bit = ^data (over the DATA_BITS bits only) -> STOP.
//   - STOP: data_out=1 for STOP_BITS*CLKS_PER_BIT cycles. Then, if FIFO non-empty, pop and go directly to START (no idle cycle); else IDLE.
// - Baud counter counts 0..CLKS_PER_BIT-1 and reloads on each bit boundary.
//   Bit counter is sized $clog2(DATA_BITS+1).
// - Latency: a word accepted at edge k while IDLE and FIFO empty -> data_out=0 from edge k+2.
// - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
//   Back-to-back frames are exactly this period apart.
// - data_out is driven from a flop (glitch-free).
// - tx_busy = (FSM != IDLE) | (fifo_level != 0).
// - tx_data is sampled only on an accepted edge; its value at any other time is ignored.
// TESTING
// (bench uses CLKS_PER_BIT=4)
// 1. Reset, then push 8'hA5 once (8N1) -> line: 0,1,0,1,0,0,1,0,1,1, 4 cycles per bit;
//    falling edge 2 cycles after acceptance; tx_busy drops after 40 cycles.
// 2. PARITY=2, push 8'h07 -> parity bit 1; PARITY=1 -> parity bit 0.
//    Frame is 44 cycles; with STOP_BITS=2 it is 48 cycles.
// 3. Hold tx_valid with 6 words into FIFO_DEPTH=4 -> tx_ready low once 4 words are queued.
//    All 6 words appear in order; every frame is 40 cycles with no gap between frames.
// 4. DATA_BITS=5, push 5'h1B -> bits 1,1,0,1,1 after the start bit; frame is 32 cycles.
// 5. Assert rst during DATA bit 3 -> data_out=1 next edge; fifo_level=0; tx_ready=1 after release;
//    the next push produces a clean frame.
// 6. Push on the same edge the FSM pops the last queued word -> fifo_level unchanged; no word lost or duplicated.

Source files
------------

// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Parametrised UART transmitter with an input FIFO.
//               Host pushes words over a valid/ready handshake. Frames are
//               sent LSB first: a start bit, DATA_BITS data bits, an
//               optional parity bit, then STOP_BITS stop bits. Queued words
//               go out back to back with no idle cycle between frames.
//
//               Ports
//                 clk        : system clock, rising edge
//                 rst        : synchronous reset, active high
//                 tx_data    : word to queue (DATA_BITS wide)
//                 tx_valid   : tx_data valid this cycle
//                 tx_ready   : FIFO can accept a word
//                 data_out   : serial line, idle high, driven from a flop
//                 tx_busy    : frame in progress or words still queued
//                 fifo_level : words queued and not yet started
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          data_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_bw = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_cw = $clog2(DATA_BITS + 1);

    localparam logic [c_aw:0]   c_fifo_full = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_aw:0]   c_cnt_one   = (c_aw + 1)'(1);
    localparam logic [c_bw-1:0] c_baud_last = c_bw'(CLKS_PER_BIT - 1);
    localparam logic [c_bw-1:0] c_baud_one  = c_bw'(1);
    localparam logic [c_cw-1:0] c_data_last = c_cw'(DATA_BITS - 1);
    localparam logic [c_cw-1:0] c_stop_last = c_cw'(STOP_BITS - 1);
    localparam logic [c_cw-1:0] c_bit_one   = c_cw'(1);

    // FSM encoding
    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_start  = 3'd1;
    localparam logic [2:0] c_data   = 3'd2;
    localparam logic [2:0] c_parity = 3'd3;
    localparam logic [2:0] c_stop   = 3'd4;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_aw:0]        r_count;

    logic [2:0]           r_state;
    logic [c_bw-1:0]      r_baud;
    logic [c_cw-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_data_out;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_end;
    logic                 w_stop_end;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;
    logic                 w_line;

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------
    assign w_full   = (r_count == c_fifo_full);
    assign w_empty  = (r_count == '0);
    // Ready looks only at registered occupancy, so a full FIFO refuses a
    // push even when the FSM pops on the same edge.
    assign tx_ready = !w_full && !rst;
    assign w_push   = tx_valid && tx_ready;

    assign w_baud_end = (r_baud == c_baud_last);
    assign w_stop_end = (r_state == c_stop) && w_baud_end && (r_bit_cnt == c_stop_last);
    // Pop from IDLE, or on the final cycle of the last stop bit so the next
    // start bit follows with no idle gap.
    assign w_pop      = !w_empty && ((r_state == c_idle) || w_stop_end);

    assign w_head     = r_mem[r_rd_ptr];
    // Parity over the data bits only: odd -> xnor-reduce, even -> xor-reduce.
    assign w_head_par = (PARITY == 1) ? ~^w_head : ^w_head;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line level for the current state; registered one cycle later, which
    // puts the first start-bit cycle two edges after the word is accepted.
    // ------------------------------------------------------------------
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            c_start:  w_line = 1'b0;
            c_data:   w_line = r_shift[0];
            c_parity: w_line = r_par_bit;
            default:  w_line = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_data_out <= 1'b1;
        end else begin
            r_data_out <= w_line;
            case (r_state)
                c_idle: begin
                    r_baud    <= '0;
                    r_bit_cnt <= '0;
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_par_bit <= w_head_par;
                        r_state   <= c_start;
                    end
                end
                c_start: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= c_data;
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
                c_data: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == c_data_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? c_parity : c_stop;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_bit_one;
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
                c_parity: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= c_stop;
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
                c_stop: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        // Bit counter is reused to count stop bits.
                        if (r_bit_cnt == c_stop_last) begin
                            r_bit_cnt <= '0;
                            if (w_pop) begin
                                r_shift   <= w_head;
                                r_par_bit <= w_head_par;
                                r_state   <= c_start;
                            end else begin
                                r_state <= c_idle;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_bit_one;
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
                default: begin
                    r_state   <= c_idle;
                    r_baud    <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign tx_busy    = (r_state != c_idle) || !w_empty;
    assign fifo_level = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Directed testbench for uart_tx_cfg. Five instances cover
//               8N1, 8E1, 8O1, 8E2 and 5N2 framing at 4 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int c_cpb = 4;

    logic       clk;
    logic       rst;
    logic [4:0] valid;
    logic [7:0] d8 [4];
    logic [4:0] d5;
    logic [4:0] ready;
    logic [4:0] line;
    logic [4:0] busy;
    logic [2:0] lvl [5];

    int total;
    int bad;

    // Frame shape per instance
    int nb_of   [5] = '{8, 8, 8, 8, 5};
    int par_of  [5] = '{0, 2, 1, 2, 0};
    int stop_of [5] = '{1, 1, 1, 2, 2};
    // Hand-computed parity bit for 8'h07 (three ones): even -> 1, odd -> 0
    logic par07_want [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    uart_tx_cfg #(.CLKS_PER_BIT(c_cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx_data(d8[0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .data_out(line[0]), .tx_busy(busy[0]), .fifo_level(lvl[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(c_cpb), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_data(d8[1]), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .data_out(line[1]), .tx_busy(busy[1]), .fifo_level(lvl[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(c_cpb), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_data(d8[2]), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .data_out(line[2]), .tx_busy(busy[2]), .fifo_level(lvl[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(c_cpb), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx_data(d8[3]), .tx_valid(valid[3]), .tx_ready(ready[3]),
        .data_out(line[3]), .tx_busy(busy[3]), .fifo_level(lvl[3]));
    uart_tx_cfg #(.CLKS_PER_BIT(c_cpb), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .tx_data(d5), .tx_valid(valid[4]), .tx_ready(ready[4]),
        .data_out(line[4]), .tx_busy(busy[4]), .fifo_level(lvl[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame: bit j is the line level during bit period j.
    function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nb, input int par);
        logic [15:0] f;
        logic        p;
        int          n;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < nb; i++) begin
            f[1 + i] = d[i];
            p        = p ^ d[i];
        end
        n = 1 + nb;
        if (par == 1) f[n] = ~p;
        else if (par == 2) f[n] = p;
        return f;
    endfunction

    function automatic int frame_len(input int nb, input int par, input int stops);
        return 1 + nb + ((par != 0) ? 1 : 0) + stops;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        valid = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 5; u++) begin
            total++; if (line[u] !== 1'b1) begin bad++; $display("FAIL reset_line u%0d got=%b want=1", u, line[u]); end
            total++; if (busy[u] !== 1'b0) begin bad++; $display("FAIL reset_busy u%0d got=%b want=0", u, busy[u]); end
            total++; if (lvl[u] !== 3'd0) begin bad++; $display("FAIL reset_level u%0d got=%0d want=0", u, lvl[u]); end
            total++; if (ready[u] !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst u%0d got=%b want=0", u, ready[u]); end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int u = 0; u < 5; u++) begin
            total++; if (ready[u] !== 1'b1) begin bad++; $display("FAIL reset_ready_after u%0d got=%b want=1", u, ready[u]); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic_8n1();
        // 8'hA5 framed: 0,1,0,1,0,0,1,0,1,1
        logic [9:0] want = 10'b11_0100_1010;
        valid[0] = 1'b1;
        d8[0]    = 8'hA5;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        d8[0]    = 8'h00;
        total++; if (lvl[0] !== 3'd1) begin bad++; $display("FAIL basic_level_after_push got=%0d want=1", lvl[0]); end
        total++; if (line[0] !== 1'b1) begin bad++; $display("FAIL basic_line_k got=%b want=1", line[0]); end
        @(posedge clk);
        #1;
        total++; if (line[0] !== 1'b1) begin bad++; $display("FAIL basic_line_k1 got=%b want=1", line[0]); end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < c_cpb; c++) begin
                @(posedge clk);
                #1;
                total++;
                if (line[0] !== want[b]) begin
                    bad++; $display("FAIL basic_line bit%0d cyc%0d got=%b want=%b", b, c, line[0], want[b]);
                end
                if (b == 9 && c == 2) begin
                    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL basic_busy_in_stop got=%b want=1", busy[0]); end
                end
            end
        end
        @(posedge clk);
        #1;
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy[0]); end
        total++; if (line[0] !== 1'b1) begin bad++; $display("FAIL basic_line_end got=%b want=1", line[0]); end
    endtask

    // ------------------------------------------------------------------
    // Two words back to back on each parity instance; the second start bit
    // lands exactly one frame period after the first.
    task automatic test_parity();
        for (int u = 1; u <= 3; u++) begin
            bit          want_q[$];
            logic [15:0] fb;
            int          n;
            want_q.delete();
            n  = frame_len(nb_of[u], par_of[u], stop_of[u]);
            fb = frame_bits(9'h007, nb_of[u], par_of[u]);
            for (int j = 0; j < n; j++) want_q.push_back(fb[j]);
            fb = frame_bits(9'h080, nb_of[u], par_of[u]);
            for (int j = 0; j < n; j++) want_q.push_back(fb[j]);

            valid[u] = 1'b1;
            d8[u]    = 8'h07;
            @(posedge clk);
            #1;
            d8[u] = 8'h80;
            @(posedge clk);
            #1;
            valid[u] = 1'b0;
            d8[u]    = 8'h00;
            // second push coincided with the IDLE pop of the first word
            total++; if (lvl[u] !== 3'd1) begin bad++; $display("FAIL parity_push_pop_level u%0d got=%0d want=1", u, lvl[u]); end
            for (int s = 0; s < want_q.size() * c_cpb; s++) begin
                @(posedge clk);
                #1;
                total++;
                if (line[u] !== want_q[s / c_cpb]) begin
                    bad++; $display("FAIL parity_line u%0d cyc%0d got=%b want=%b", u, s, line[u], want_q[s / c_cpb]);
                end
                if (s == 9 * c_cpb + 1) begin
                    total++;
                    if (line[u] !== par07_want[u]) begin
                        bad++; $display("FAIL parity_bit u%0d got=%b want=%b", u, line[u], par07_want[u]);
                    end
                end
            end
            @(posedge clk);
            #1;
            total++; if (line[u] !== 1'b1 || busy[u] !== 1'b0) begin
                bad++; $display("FAIL parity_end u%0d line=%b busy=%b want line=1 busy=0", u, line[u], busy[u]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_5bit();
        // 5'h1B framed with two stops: 0,1,1,0,1,1,1,1 ; 5'h04: 0,0,0,1,0,0,1,1
        logic [15:0] want = 16'b1100_1000_1111_0110;
        valid[4] = 1'b1;
        d5       = 5'h1B;
        @(posedge clk);
        #1;
        d5 = 5'h04;
        @(posedge clk);
        #1;
        valid[4] = 1'b0;
        d5       = 5'h00;
        total++; if (lvl[4] !== 3'd1) begin bad++; $display("FAIL five_level got=%0d want=1", lvl[4]); end
        for (int s = 0; s < 16 * c_cpb; s++) begin
            @(posedge clk);
            #1;
            total++;
            if (line[4] !== want[s / c_cpb]) begin
                bad++; $display("FAIL five_line cyc%0d got=%b want=%b", s, line[4], want[s / c_cpb]);
            end
        end
        @(posedge clk);
        #1;
        total++; if (busy[4] !== 1'b0) begin bad++; $display("FAIL five_busy_end got=%b want=0", busy[4]); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fifo_full();
        logic [7:0]  w [6] = '{8'h31, 8'hC4, 8'h5A, 8'hFF, 8'h00, 8'h96};
        bit          want_q[$];
        logic [15:0] fb;
        want_q.delete();
        for (int i = 0; i < 6; i++) begin
            fb = frame_bits({1'b0, w[i]}, 8, 0);
            for (int j = 0; j < 10; j++) want_q.push_back(fb[j]);
        end
        fork
            begin : pusher
                int idx;
                int guard;
                bit saw_full;
                bit acc;
                idx      = 0;
                guard    = 0;
                saw_full = 1'b0;
                valid[0] = 1'b1;
                d8[0]    = w[0];
                while (idx < 6 && guard < 400) begin
                    acc = ready[0];
                    @(posedge clk);
                    #1;
                    guard++;
                    if (acc) idx++;
                    if (lvl[0] == 3'd4 && !saw_full) begin
                        saw_full = 1'b1;
                        total++;
                        if (ready[0] !== 1'b0) begin bad++; $display("FAIL fifo_ready_when_full got=%b want=0", ready[0]); end
                    end
                    if (idx < 6) d8[0] = w[idx];
                    else valid[0] = 1'b0;
                end
                valid[0] = 1'b0;
                total++;
                if (idx != 6 || !saw_full) begin
                    bad++; $display("FAIL fifo_push_done accepted=%0d saw_full=%0d want 6 and 1", idx, saw_full);
                end
            end
            begin : watcher
                bit found;
                found = 1'b0;
                for (int i = 0; i < 10 && !found; i++) begin
                    @(posedge clk);
                    #1;
                    if (line[0] === 1'b0) found = 1'b1;
                end
                total++;
                if (!found) begin
                    bad++; $display("FAIL fifo_first_start got=none want=start within 10 cycles");
                end else begin
                    for (int s = 1; s < 60 * c_cpb; s++) begin
                        @(posedge clk);
                        #1;
                        total++;
                        if (line[0] !== want_q[s / c_cpb]) begin
                            bad++; $display("FAIL fifo_line cyc%0d got=%b want=%b", s, line[0], want_q[s / c_cpb]);
                        end
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        total++; if (busy[0] !== 1'b0 || lvl[0] !== 3'd0 || line[0] !== 1'b1) begin
            bad++; $display("FAIL fifo_end busy=%b level=%0d line=%b want 0 0 1", busy[0], lvl[0], line[0]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        logic [9:0] want = 10'b10_0111_1000;  // 8'h3C framed
        bit         saw_low;
        valid[0] = 1'b1;
        d8[0]    = 8'hA5;
        @(posedge clk);
        #1;
        d8[0] = 8'h3C;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        d8[0]    = 8'h00;
        repeat (18) @(posedge clk);
        #1;
        // data bit 3 of 8'hA5 is 0
        total++; if (line[0] !== 1'b0) begin bad++; $display("FAIL rmid_bit3 got=%b want=0", line[0]); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (line[0] !== 1'b1) begin bad++; $display("FAIL rmid_line got=%b want=1", line[0]); end
        total++; if (lvl[0] !== 3'd0) begin bad++; $display("FAIL rmid_level got=%0d want=0", lvl[0]); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy[0]); end
        total++; if (ready[0] !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_rst got=%b want=0", ready[0]); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (ready[0] !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got=%b want=1", ready[0]); end
        saw_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (line[0] !== 1'b1) saw_low = 1'b1;
        end
        total++; if (saw_low) begin bad++; $display("FAIL rmid_discard got=line_low want=idle_high"); end
        valid[0] = 1'b1;
        d8[0]    = 8'h3C;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        @(posedge clk);
        #1;
        for (int s = 0; s < 10 * c_cpb; s++) begin
            @(posedge clk);
            #1;
            total++;
            if (line[0] !== want[s / c_cpb]) begin
                bad++; $display("FAIL rmid_clean_line cyc%0d got=%b want=%b", s, line[0], want[s / c_cpb]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // A push lands on the STOP-end edge that pops the last queued word.
    task automatic test_same_edge();
        logic [7:0]  w [3] = '{8'h11, 8'h22, 8'h33};
        bit          want_q[$];
        logic [15:0] fb;
        want_q.delete();
        for (int i = 0; i < 3; i++) begin
            fb = frame_bits({1'b0, w[i]}, 8, 0);
            for (int j = 0; j < 10; j++) want_q.push_back(fb[j]);
        end
        @(posedge clk);
        #1;
        valid[0] = 1'b1;
        d8[0]    = w[0];
        @(posedge clk);
        #1;
        d8[0] = w[1];
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        d8[0]    = 8'h00;
        total++; if (lvl[0] !== 3'd1) begin bad++; $display("FAIL same_level_idle_pop got=%0d want=1", lvl[0]); end
        for (int s = 0; s < 30 * c_cpb; s++) begin
            @(posedge clk);
            #1;
            total++;
            if (line[0] !== want_q[s / c_cpb]) begin
                bad++; $display("FAIL same_line cyc%0d got=%b want=%b", s, line[0], want_q[s / c_cpb]);
            end
            if (s == 38) begin
                valid[0] = 1'b1;
                d8[0]    = w[2];
            end
            if (s == 39) begin
                valid[0] = 1'b0;
                d8[0]    = 8'h00;
                total++; if (lvl[0] !== 3'd1) begin bad++; $display("FAIL same_level_stop_pop got=%0d want=1", lvl[0]); end
            end
        end
        @(posedge clk);
        #1;
        total++; if (busy[0] !== 1'b0 || lvl[0] !== 3'd0) begin
            bad++; $display("FAIL same_end busy=%b level=%0d want 0 0", busy[0], lvl[0]);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        valid = '0;
        d5    = '0;
        for (int i = 0; i < 4; i++) d8[i] = '0;
        test_reset();
        test_basic_8n1();
        test_parity();
        test_5bit();
        test_fifo_full();
        test_reset_mid();
        test_same_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
